// File: rtl/sprite_pkg.sv
// Shared defaults, widths and packing helpers for the multi-channel sprite renderer.
package sprite_pkg;

    localparam int unsigned DEF_SPR_W      = 10;
    localparam int unsigned DEF_SHEET_W    = 360;
    localparam int unsigned DEF_SHEET_SIZE = 86400;
    localparam int unsigned DEF_FRM_W      = 4;

    localparam int unsigned COORD_W = 9;
    localparam int unsigned CMP_W   = COORD_W + 1;
    localparam int unsigned ADDR_W  = 17;
    localparam int unsigned CALC_W  = 20;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned CNT_W   = 10;

    // LSB position of lane idx inside a packed per-sprite bus of lane width w
    function automatic int unsigned lane_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/sprite_anim.sv
// Single-channel animation: frame_tick divider plus wrapping frame counter.
module sprite_anim #(
    parameter int unsigned ANIM_DIV = 8,
    parameter int unsigned FRM_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             anim_en,
    input  logic             anim_restart,
    input  logic [FRM_W-1:0] nfrm,
    output logic [FRM_W-1:0] frm
);

    localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam int unsigned INC_W = FRM_W + 1;

    logic [DIV_W-1:0] div_q;
    logic [INC_W-1:0] frm_inc;
    logic             step_done;

    assign frm_inc   = {1'b0, frm} + INC_W'(1);
    assign step_done = (div_q == DIV_W'(ANIM_DIV - 1));

    // Restart beats a coincident advance; a shrunk nfrm takes effect at the next advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            frm   <= '0;
        end else if (anim_restart) begin
            div_q <= '0;
            frm   <= '0;
        end else if (anim_en && frame_tick) begin
            if (step_done) begin
                div_q <= '0;
                frm   <= (frm_inc >= {1'b0, nfrm}) ? '0 : frm_inc[FRM_W-1:0];
            end else begin
                div_q <= div_q + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_engine.sv
// N-channel sprite renderer: per-sprite hit/address, fixed-priority select, 2-stage pipeline.
module sprite_engine
    import sprite_pkg::*;
#(
    parameter int unsigned N_SPR       = 4,
    parameter int unsigned SPR_W       = DEF_SPR_W,
    parameter int unsigned SHEET_W     = DEF_SHEET_W,
    parameter int unsigned SHEET_SIZE  = DEF_SHEET_SIZE,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned ANIM_DIV    = 8,
    parameter int unsigned FRM_W       = DEF_FRM_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CNT_W-1:0]           h_cnt,
    input  logic [CNT_W-1:0]           v_cnt,
    input  logic                       frame_tick,
    input  logic [N_SPR-1:0]           spr_en,
    input  logic [N_SPR*COORD_W-1:0]   spr_x,
    input  logic [N_SPR*COORD_W-1:0]   spr_y,
    input  logic [N_SPR*COORD_W-1:0]   spr_row,
    input  logic [N_SPR*FRM_W-1:0]     spr_nfrm,
    input  logic [N_SPR-1:0]           anim_en,
    input  logic [N_SPR-1:0]           anim_restart,
    output logic [ADDR_W-1:0]          pix_addr,
    output logic                       pix_valid,
    output logic [ID_W-1:0]            pix_id,
    output logic [N_SPR*FRM_W-1:0]     anim_frm
);

    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [N_SPR-1:0]   hit_c;
    logic [ADDR_W-1:0]  addr_c [N_SPR];
    logic [N_SPR-1:0]   hit_q;
    logic [ADDR_W-1:0]  addr_q [N_SPR];

    logic               win_valid;
    logic [ID_W-1:0]    win_id;
    logic [ADDR_W-1:0]  win_addr;

    assign x = COORD_W'(h_cnt >> SCALE_SHIFT);
    assign y = COORD_W'(v_cnt >> SCALE_SHIFT);

    for (genvar gi = 0; gi < N_SPR; gi++) begin : g_spr
        logic [COORD_W-1:0] sx;
        logic [COORD_W-1:0] sy;
        logic [COORD_W-1:0] row;
        logic [FRM_W-1:0]   frm;
        logic               in_x;
        logic               in_y;
        logic [CALC_W-1:0]  lin;

        assign sx  = spr_x[lane_lo(gi, COORD_W) +: COORD_W];
        assign sy  = spr_y[lane_lo(gi, COORD_W) +: COORD_W];
        assign row = spr_row[lane_lo(gi, COORD_W) +: COORD_W];

        // Bounds widened by one bit so sx+SPR_W near the right edge cannot wrap to 0
        assign in_x = ({1'b0, x} >= {1'b0, sx}) && ({1'b0, x} < ({1'b0, sx} + CMP_W'(SPR_W)));
        assign in_y = ({1'b0, y} >= {1'b0, sy}) && ({1'b0, y} < ({1'b0, sy} + CMP_W'(SPR_W)));
        assign hit_c[gi] = spr_en[gi] && in_x && in_y;

        assign lin = (CALC_W'(x) - CALC_W'(sx))
                   + CALC_W'(SPR_W) * CALC_W'(frm)
                   + (CALC_W'(y) - CALC_W'(sy) + CALC_W'(row)) * CALC_W'(SHEET_W);
        assign addr_c[gi] = ADDR_W'(lin % CALC_W'(SHEET_SIZE));

        sprite_anim #(
            .ANIM_DIV (ANIM_DIV),
            .FRM_W    (FRM_W)
        ) u_anim (
            .clk          (clk),
            .rst          (rst),
            .frame_tick   (frame_tick),
            .anim_en      (anim_en[gi]),
            .anim_restart (anim_restart[gi]),
            .nfrm         (spr_nfrm[lane_lo(gi, FRM_W) +: FRM_W]),
            .frm          (frm)
        );

        assign anim_frm[lane_lo(gi, FRM_W) +: FRM_W] = frm;
    end

    // Stage 1: per-sprite hit and address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= '0;
            for (int i = 0; i < N_SPR; i++) begin
                addr_q[i] <= '0;
            end
        end else begin
            hit_q <= hit_c;
            for (int i = 0; i < N_SPR; i++) begin
                addr_q[i] <= addr_c[i];
            end
        end
    end

    // Descending scan so the lowest-index hit is the last writer
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        win_addr  = '0;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                win_valid = 1'b1;
                win_id    = ID_W'(i);
                win_addr  = addr_q[i];
            end
        end
    end

    // Stage 2: winning sprite
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_id    <= '0;
            pix_addr  <= '0;
        end else begin
            pix_valid <= win_valid;
            pix_id    <= win_id;
            pix_addr  <= win_addr;
        end
    end

endmodule

// File: tb/tb_sprite_engine.sv
// Directed scoreboard bench for sprite_engine: pixel pipeline, priority, edges, animation, reset.
module tb_sprite_engine;

    localparam int N = 4;

    typedef logic [20:0] pix_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic          frame_tick;
    logic [N-1:0]  spr_en;
    logic [N*9-1:0] spr_x;
    logic [N*9-1:0] spr_y;
    logic [N*9-1:0] spr_row;
    logic [N*4-1:0] spr_nfrm;
    logic [N-1:0]  anim_en;
    logic [N-1:0]  anim_restart;
    logic [16:0]   pix_addr;
    logic          pix_valid;
    logic [2:0]    pix_id;
    logic [N*4-1:0] anim_frm;

    pix_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   mdiv[N];
    int   mfrm[N];

    always #5 clk = ~clk;

    sprite_engine dut (
        .clk          (clk),
        .rst          (rst),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .frame_tick   (frame_tick),
        .spr_en       (spr_en),
        .spr_x        (spr_x),
        .spr_y        (spr_y),
        .spr_row      (spr_row),
        .spr_nfrm     (spr_nfrm),
        .anim_en      (anim_en),
        .anim_restart (anim_restart),
        .pix_addr     (pix_addr),
        .pix_valid    (pix_valid),
        .pix_id       (pix_id),
        .anim_frm     (anim_frm)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_spr(input int i, input int x, input int y, input int row);
        spr_x[i*9 +: 9]   = 9'(x);
        spr_y[i*9 +: 9]   = 9'(y);
        spr_row[i*9 +: 9] = 9'(row);
    endtask

    function automatic pix_t model_pix();
        int x;
        int y;
        int sx;
        int sy;
        int row;
        int a;
        x = int'(h_cnt) / 2;
        y = int'(v_cnt) / 2;
        for (int i = 0; i < N; i++) begin
            sx  = int'(spr_x[i*9 +: 9]);
            sy  = int'(spr_y[i*9 +: 9]);
            row = int'(spr_row[i*9 +: 9]);
            if (spr_en[i] && x >= sx && x < sx + 10 && y >= sy && y < sy + 10) begin
                a = ((x - sx) + 10 * mfrm[i] + (y - sy + row) * 360) % 86400;
                return {1'b1, 3'(i), 17'(a)};
            end
        end
        return '0;
    endfunction

    function automatic logic [N*4-1:0] model_frm();
        logic [N*4-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*4 +: 4] = 4'(mfrm[i]);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mdiv[i] = 0;
            mfrm[i] = 0;
        end
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    task automatic step(input logic tick, input logic [N-1:0] restart);
        int nf;
        pix_t e;
        frame_tick   = tick;
        anim_restart = restart;
        exp_q.push_back(model_pix());
        for (int i = 0; i < N; i++) begin
            nf = int'(spr_nfrm[i*4 +: 4]);
            if (restart[i]) begin
                mdiv[i] = 0;
                mfrm[i] = 0;
            end else if (anim_en[i] && tick) begin
                if (mdiv[i] == 7) begin
                    mdiv[i] = 0;
                    mfrm[i] = (mfrm[i] + 1 >= nf) ? 0 : mfrm[i] + 1;
                end else begin
                    mdiv[i] = mdiv[i] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("anim_frm", 32'(anim_frm), 32'(model_frm()));
        if (exp_q.size() >= 2) begin
            e = exp_q.pop_front();
            chk("pix", 32'({pix_valid, pix_id, pix_addr}), 32'(e));
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(1'b1, '0);
    endtask

    initial begin
        rst          = 1'b1;
        h_cnt        = '0;
        v_cnt        = '0;
        frame_tick   = 1'b0;
        spr_en       = '0;
        spr_x        = '0;
        spr_y        = '0;
        spr_row      = '0;
        spr_nfrm     = '0;
        anim_en      = '0;
        anim_restart = '0;
        #12;
        chk("rst_valid", 32'(pix_valid), 32'd0);
        chk("rst_addr", 32'(pix_addr), 32'd0);
        chk("rst_id", 32'(pix_id), 32'd0);
        chk("rst_frm", 32'(anim_frm), 32'd0);
        rst = 1'b0;
        model_reset();

        // single sprite
        set_spr(0, 100, 50, 0);
        spr_en = 4'b0001;
        h_cnt  = 10'd204;
        v_cnt  = 10'd104;
        step(0, '0);
        step(0, '0);
        chk("t1_valid", 32'(pix_valid), 32'd1);
        chk("t1_id", 32'(pix_id), 32'd0);
        chk("t1_addr", 32'(pix_addr), 32'd722);

        // overlap priority
        set_spr(2, 100, 50, 220);
        spr_en = 4'b0101;
        step(0, '0);
        step(0, '0);
        chk("ovl_id", 32'(pix_id), 32'd0);
        chk("ovl_addr", 32'(pix_addr), 32'd722);
        spr_en = 4'b0100;
        step(0, '0);
        step(0, '0);
        chk("ovl2_id", 32'(pix_id), 32'd2);
        chk("ovl2_addr", 32'(pix_addr), 32'd79922);

        // right/left edges
        h_cnt = 10'd218;
        step(0, '0);
        step(0, '0);
        chk("edge9_valid", 32'(pix_valid), 32'd1);
        chk("edge9_addr", 32'(pix_addr), 32'd79929);
        h_cnt = 10'd220;
        step(0, '0);
        step(0, '0);
        chk("edge10_valid", 32'(pix_valid), 32'd0);
        chk("edge10_addr", 32'(pix_addr), 32'd0);

        // no wrap near right screen edge
        set_spr(1, 315, 0, 0);
        spr_en = 4'b0010;
        h_cnt  = 10'd0;
        v_cnt  = 10'd10;
        step(0, '0);
        step(0, '0);
        chk("nowrap_valid", 32'(pix_valid), 32'd0);
        h_cnt = 10'd638;
        step(0, '0);
        step(0, '0);
        chk("right_valid", 32'(pix_valid), 32'd1);
        chk("right_id", 32'(pix_id), 32'd1);
        chk("right_addr", 32'(pix_addr), 32'd1804);

        // animation
        set_spr(3, 200, 200, 0);
        spr_nfrm[15:12] = 4'd3;
        spr_en  = 4'b1000;
        anim_en = 4'b1000;
        h_cnt   = 10'd400;
        v_cnt   = 10'd400;
        ticks(8);
        chk("anim8", 32'(anim_frm[15:12]), 32'd1);
        ticks(8);
        chk("anim16", 32'(anim_frm[15:12]), 32'd2);
        step(0, '0);
        step(0, '0);
        chk("frm2_addr", 32'(pix_addr), 32'd20);
        ticks(8);
        chk("anim24", 32'(anim_frm[15:12]), 32'd0);

        // restart against a coincident advance
        ticks(8);
        chk("pre_rs", 32'(anim_frm[15:12]), 32'd1);
        ticks(7);
        step(1, 4'b1000);
        chk("restart", 32'(anim_frm[15:12]), 32'd0);
        ticks(7);
        chk("rs_div0", 32'(anim_frm[15:12]), 32'd0);
        ticks(1);
        chk("rs_adv", 32'(anim_frm[15:12]), 32'd1);

        // disabled animation holds
        anim_en = '0;
        ticks(16);
        chk("hold", 32'(anim_frm[15:12]), 32'd1);

        // reset while a pixel is valid
        spr_en = 4'b0001;
        h_cnt  = 10'd204;
        v_cnt  = 10'd104;
        step(0, '0);
        step(0, '0);
        chk("pre_rst_valid", 32'(pix_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(pix_valid), 32'd0);
        chk("mid_rst_addr", 32'(pix_addr), 32'd0);
        chk("mid_rst_frm", 32'(anim_frm), 32'd0);
        model_reset();
        #3;
        rst = 1'b0;
        step(0, '0);
        chk("post1_valid", 32'(pix_valid), 32'd0);
        step(0, '0);
        chk("post2_valid", 32'(pix_valid), 32'd1);
        chk("post2_addr", 32'(pix_addr), 32'd722);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
